lcd_access_scheduler: RTL and testbench
=======================================

Name: lcd_access_scheduler

Overview:
- Sequences and shares the single LCD_controller instance between two character requesters and a clear-screen requester.
- After reset it runs the fixed LCD init sequence, then arbitrates requests.
- Tracks the cursor over 2 lines x NUM_COLS columns and inserts line-change instructions automatically.
- Sits between the PS2 / message sources and LCD_controller, driving its LCD_start / LCD_instruction / LCD_done handshake.

Parameters:
NUM_COLS, 16, columns per LCD line; power of two, max 16.

Ports:
Clock_50  in  1  system clock, 50 MHz
Resetn  in  1  reset, asynchronous, active-low
Req_char  in  2  per-requester character write request; level, held until granted
Req_data_0  in  8  LCD character code, requester 0
Req_data_1  in  8  LCD character code, requester 1
Req_clear  in  1  clear-display request; level, held until granted
Grant  out  3  one-cycle grant pulse: [0] req 0, [1] req 1, [2] clear
Busy  out  1  high in every state except S_IDLE
Init_done  out  1  high once the init sequence completes; stays high until reset
LCD_start  out  1  to LCD_controller: one-cycle start pulse
LCD_instruction  out  9  to LCD_controller: {cmd/data select, code}
LCD_done  in  1  from LCD_controller: instruction complete
Cursor_position  out  4  current column, 0..NUM_COLS-1
Cursor_line  out  1  current line, 0 = top

Behaviour:
- Reset values: state S_INIT_ISSUE, init index 0, Grant 0, Busy 1, Init_done 0, LCD_start 0, LCD_instruction 9'h000, Cursor_position 0, Cursor_line 0, round-robin pointer 0. Reset takes effect at any time, including mid-instruction; the init sequence restarts.
- LCD handshake:
  - LCD_start is high exactly one cycle per instruction, set together with LCD_instruction.
  - LCD_instruction holds until the next issue.
  - In each WAIT state, the cycle where LCD_start is high only clears LCD_start; LCD_done is sampled from the following cycle onward.
- Init sequence: 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, using S_INIT_ISSUE / S_INIT_WAIT per entry. After done of entry 4: Init_done=1, cursor 0/0, go to S_IDLE. Requests are ignored (no Grant) until then.
- S_IDLE arbitration, evaluated each cycle:
  - Req_clear has the highest priority.
  - Otherwise, if both Req_char bits are set, grant the requester not equal to the RR pointer; otherwise grant the single requester.
  - The winner gets Grant high for 1 cycle (the transition cycle). The char code is latched that same cycle, and the RR pointer is set to the winner index.
  - Granting happens only in S_IDLE, so at most one Grant bit per cycle.
- Char path: S_ISSUE_CHAR issues {1'b1, latched code}, then S_WAIT_CHAR. On LCD_done:
  - if Cursor_position < NUM_COLS-1: increment it, go to S_IDLE;
  - else: Cursor_position=0, toggle Cursor_line, go to S_ISSUE_ADDR.
- Line change: S_ISSUE_ADDR issues 9'h080 if the new line is 0, 9'h0C0 if line 1; then S_WAIT_ADDR; on done go to S_IDLE. Wrap from line 1 returns to line 0 (0x080).
- Clear path: S_ISSUE_CLEAR issues 9'h001, then S_WAIT_CLEAR. On done, S_ISSUE_HOME issues 9'h080, then S_WAIT_HOME. On done: cursor 0/0, go to S_IDLE.
- Simultaneous clear and char: clear is granted; the char request stays pending and is granted on the first S_IDLE cycle after the clear completes.
- A request dropped before grant is forgotten. A request still held after its Grant is treated as a new request.
- Busy = (state != S_IDLE). No output changes while LCD_done stays low indefinitely; there is no timeout.
- Unused state encodings go to S_INIT_ISSUE.

Test Plan:
- Release reset, LCD model asserts done 5 cycles after each start -> exactly 5 starts, instructions 038, 00C, 001, 006, 080 in order; Init_done rises after the 5th done; Req_char[0] held during init gets no Grant.
- After init, Req_char=01, Req_data_0=8'h41 -> Grant=001 for one cycle, one start with LCD_instruction=9'h141, Cursor_position 0->1 after done.
- 16 chars from requester 0 -> 16th done gives Cursor_position 0, Cursor_line 1, followed by start with 9'h0C0. 32 chars -> ends with 9'h080, Cursor_line 0.
- Req_char=11 held continuously, RR pointer 0 -> grants alternate 010, 001, 010, ... with instruction data matching the granted requester.
- Req_clear and Req_char[1] asserted together in S_IDLE with cursor at 5/1 -> Grant=100, instructions 001 then 080, cursor 0/0; then Grant=010 and its char is issued.
- Resetn pulsed low while in S_WAIT_CHAR -> all outputs return to reset values immediately; init sequence reissued from 038.

Source files
------------

// File: rtl/lcd_access_scheduler.sv
// Runs the LCD power-up init sequence, then shares one LCD_controller between two character
// requesters and a clear requester, tracking the cursor over two lines.
module lcd_access_scheduler #(
    parameter int unsigned NUM_COLS = 16
) (
    input  logic       Clock_50,
    input  logic       Resetn,
    input  logic [1:0] Req_char,
    input  logic [7:0] Req_data_0,
    input  logic [7:0] Req_data_1,
    input  logic       Req_clear,
    output logic [2:0] Grant,
    output logic       Busy,
    output logic       Init_done,
    output logic       LCD_start,
    output logic [8:0] LCD_instruction,
    input  logic       LCD_done,
    output logic [3:0] Cursor_position,
    output logic       Cursor_line
);

    typedef enum logic [3:0] {
        S_INIT_ISSUE  = 4'd0,
        S_INIT_WAIT   = 4'd1,
        S_IDLE        = 4'd2,
        S_ISSUE_CHAR  = 4'd3,
        S_WAIT_CHAR   = 4'd4,
        S_ISSUE_ADDR  = 4'd5,
        S_WAIT_ADDR   = 4'd6,
        S_ISSUE_CLEAR = 4'd7,
        S_WAIT_CLEAR  = 4'd8,
        S_ISSUE_HOME  = 4'd9,
        S_WAIT_HOME   = 4'd10
    } state_t;

    localparam logic [3:0] LastCol = 4'(NUM_COLS - 1);

    state_t     state_q, state_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic [7:0] char_q, char_d;
    logic       rr_q, rr_d;
    logic [2:0] grant_d;
    logic       start_d;
    logic [8:0] instr_d;
    logic       init_done_d;
    logic [3:0] pos_d;
    logic       line_d;
    logic       win;
    logic [8:0] init_code;
    logic       done_seen;

    always_comb begin
        case (init_idx_q)
            3'd0:    init_code = 9'h038;
            3'd1:    init_code = 9'h00C;
            3'd2:    init_code = 9'h001;
            3'd3:    init_code = 9'h006;
            default: init_code = 9'h080;
        endcase
    end

    // The start cycle of every WAIT state only retires LCD_start; done counts afterwards.
    assign done_seen = !LCD_start && LCD_done;
    assign Busy      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        char_d      = char_q;
        rr_d        = rr_q;
        grant_d     = 3'b000;
        start_d     = 1'b0;
        instr_d     = LCD_instruction;
        init_done_d = Init_done;
        pos_d       = Cursor_position;
        line_d      = Cursor_line;
        win         = 1'b0;
        case (state_q)
            S_INIT_ISSUE: begin
                start_d = 1'b1;
                instr_d = init_code;
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (done_seen) begin
                    if (init_idx_q == 3'd4) begin
                        init_done_d = 1'b1;
                        pos_d       = 4'd0;
                        line_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        state_d    = S_INIT_ISSUE;
                    end
                end
            end
            S_IDLE: begin
                if (Req_clear) begin
                    grant_d = 3'b100;
                    state_d = S_ISSUE_CLEAR;
                end else if (Req_char != 2'b00) begin
                    win     = (Req_char == 2'b11) ? ~rr_q : Req_char[1];
                    grant_d = win ? 3'b010 : 3'b001;
                    char_d  = win ? Req_data_1 : Req_data_0;
                    rr_d    = win;
                    state_d = S_ISSUE_CHAR;
                end
            end
            S_ISSUE_CHAR: begin
                start_d = 1'b1;
                instr_d = {1'b1, char_q};
                state_d = S_WAIT_CHAR;
            end
            S_WAIT_CHAR: begin
                if (done_seen) begin
                    if (Cursor_position < LastCol) begin
                        pos_d   = Cursor_position + 4'd1;
                        state_d = S_IDLE;
                    end else begin
                        pos_d   = 4'd0;
                        line_d  = ~Cursor_line;
                        state_d = S_ISSUE_ADDR;
                    end
                end
            end
            S_ISSUE_ADDR: begin
                start_d = 1'b1;
                instr_d = Cursor_line ? 9'h0C0 : 9'h080;
                state_d = S_WAIT_ADDR;
            end
            S_WAIT_ADDR: begin
                if (done_seen) state_d = S_IDLE;
            end
            S_ISSUE_CLEAR: begin
                start_d = 1'b1;
                instr_d = 9'h001;
                state_d = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                if (done_seen) state_d = S_ISSUE_HOME;
            end
            S_ISSUE_HOME: begin
                start_d = 1'b1;
                instr_d = 9'h080;
                state_d = S_WAIT_HOME;
            end
            S_WAIT_HOME: begin
                if (done_seen) begin
                    pos_d   = 4'd0;
                    line_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT_ISSUE;
        endcase
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= S_INIT_ISSUE;
            init_idx_q      <= 3'd0;
            char_q          <= 8'h00;
            rr_q            <= 1'b0;
            Grant           <= 3'b000;
            LCD_start       <= 1'b0;
            LCD_instruction <= 9'h000;
            Init_done       <= 1'b0;
            Cursor_position <= 4'd0;
            Cursor_line     <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_idx_q      <= init_idx_d;
            char_q          <= char_d;
            rr_q            <= rr_d;
            Grant           <= grant_d;
            LCD_start       <= start_d;
            LCD_instruction <= instr_d;
            Init_done       <= init_done_d;
            Cursor_position <= pos_d;
            Cursor_line     <= line_d;
        end
    end

endmodule

// File: tb/tb_lcd_access_scheduler.sv
// Bench for lcd_access_scheduler: queue-based transaction model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_lcd_access_scheduler;

    localparam int unsigned NUM_COLS = 16;

    logic       Clock_50   = 1'b0;
    logic       Resetn     = 1'b1;
    logic [1:0] Req_char   = 2'b00;
    logic [7:0] Req_data_0 = 8'h00;
    logic [7:0] Req_data_1 = 8'h00;
    logic       Req_clear  = 1'b0;
    logic [2:0] Grant;
    logic       Busy;
    logic       Init_done;
    logic       LCD_start;
    logic [8:0] LCD_instruction;
    logic       LCD_done;
    logic [3:0] Cursor_position;
    logic       Cursor_line;

    lcd_access_scheduler #(.NUM_COLS(NUM_COLS)) dut (
        .Clock_50       (Clock_50),
        .Resetn         (Resetn),
        .Req_char       (Req_char),
        .Req_data_0     (Req_data_0),
        .Req_data_1     (Req_data_1),
        .Req_clear      (Req_clear),
        .Grant          (Grant),
        .Busy           (Busy),
        .Init_done      (Init_done),
        .LCD_start      (LCD_start),
        .LCD_instruction(LCD_instruction),
        .LCD_done       (LCD_done),
        .Cursor_position(Cursor_position),
        .Cursor_line    (Cursor_line)
    );

    always #10 Clock_50 = ~Clock_50;

    // LCD_controller stand-in: one-cycle done pulse about 5 cycles after each start.
    int unsigned lcd_cnt;
    bit          lcd_stall = 1'b0;
    always @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            lcd_cnt  <= 0;
            LCD_done <= 1'b0;
        end else begin
            LCD_done <= 1'b0;
            if (LCD_start) begin
                lcd_cnt <= 5;
            end else if (lcd_cnt != 0 && !lcd_stall) begin
                lcd_cnt <= lcd_cnt - 1;
                if (lcd_cnt == 1) LCD_done <= 1'b1;
            end
        end
    end

    int         n_run;
    int         n_fail;
    logic [8:0] exp_q[$];
    logic [8:0] issued[$];
    logic [2:0] grants[$];
    logic [8:0] init_tbl[5];
    logic [3:0] m_pos;
    logic       m_line;
    int         init_starts;
    logic       prev_start;
    logic [8:0] last_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(init_tbl[i]);
        m_pos       = 4'd0;
        m_line      = 1'b0;
        init_starts = 0;
        prev_start  = 1'b0;
        last_instr  = 9'h000;
    endtask

    task automatic monitor_cycle();
        logic [7:0] d;
        @(negedge Clock_50);
        if (!Resetn) begin
            check("reset_outputs",
                  32'({Grant, Busy, Init_done, LCD_start, LCD_instruction, Cursor_position,
                       Cursor_line}),
                  32'({3'b000, 1'b1, 1'b0, 1'b0, 9'h000, 4'h0, 1'b0}));
            model_reset();
        end else begin
            if (Grant != 3'b000) begin
                check("grant_onehot", 32'($onehot(Grant)), 32'd1);
                check("grant_before_init_done", 32'(init_starts), 32'd5);
                grants.push_back(Grant);
                if (Grant[2]) begin
                    exp_q.push_back(9'h001);
                    exp_q.push_back(9'h080);
                    m_pos  = 4'd0;
                    m_line = 1'b0;
                end else begin
                    d = Grant[1] ? Req_data_1 : Req_data_0;
                    exp_q.push_back({1'b1, d});
                    if (int'(m_pos) == NUM_COLS - 1) begin
                        m_pos  = 4'd0;
                        m_line = ~m_line;
                        exp_q.push_back(m_line ? 9'h0C0 : 9'h080);
                    end else begin
                        m_pos = m_pos + 4'd1;
                    end
                end
            end
            if (LCD_start) begin
                check("start_single_cycle", 32'(prev_start), 32'd0);
                check("start_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("instruction", 32'(LCD_instruction),
                                            32'(exp_q.pop_front()));
                issued.push_back(LCD_instruction);
                if (init_starts < 5) init_starts++;
            end else begin
                check("instruction_hold", 32'(LCD_instruction), 32'(last_instr));
            end
            last_instr = LCD_instruction;
            prev_start = LCD_start;
            if (init_starts < 5) check("init_done_early", 32'(Init_done), 32'd0);
            if (!Busy) begin
                check("idle_init_done", 32'(Init_done), 32'd1);
                check("idle_nothing_pending", 32'(exp_q.size()), 32'd0);
                check("idle_cursor", 32'({Cursor_line, Cursor_position}),
                      32'({m_line, m_pos}));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_50);
            if (!Busy) break;
        end
        check("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic wait_grant(input int idx, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_50);
            if (Grant[idx]) break;
        end
        check("grant_timeout", 32'(Grant[idx]), 32'd1);
    endtask

    task automatic wait_init(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock_50);
            if (Init_done) break;
        end
        check("init_timeout", 32'(Init_done), 32'd1);
    endtask

    task automatic send_char(input int idx, input logic [7:0] data);
        if (idx == 0) Req_data_0 = data;
        else Req_data_1 = data;
        Req_char[idx] = 1'b1;
        wait_grant(idx, 100);
        Req_char[idx] = 1'b0;
        wait_idle(100);
    endtask

    function automatic logic [8:0] issued_back(input int k);
        return issued[issued.size() - 1 - k];
    endfunction

    int base;

    initial begin
        n_run       = 0;
        n_fail      = 0;
        init_tbl[0] = 9'h038;
        init_tbl[1] = 9'h00C;
        init_tbl[2] = 9'h001;
        init_tbl[3] = 9'h006;
        init_tbl[4] = 9'h080;
        model_reset();
        fork
            forever monitor_cycle();
        join_none

        // Init with a request held throughout: no grant until init completes.
        #1 Resetn = 1'b0;
        Req_data_0  = 8'h55;
        Req_char[0] = 1'b1;
        repeat (3) @(negedge Clock_50);
        @(posedge Clock_50);
        #2 Resetn = 1'b1;
        wait_init(300);
        Req_char[0] = 1'b0;
        check("init_start_count", 32'(issued.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("init_sequence", 32'(issued[i]), 32'(init_tbl[i]));
        check("no_grant_during_init", 32'(grants.size()), 32'd0);
        check("init_cursor", 32'({Cursor_line, Cursor_position}), 32'd0);
        wait_idle(20);

        // Single character.
        send_char(0, 8'h41);
        check("first_grant_count", 32'(grants.size()), 32'd1);
        check("first_grant", 32'(grants[0]), 32'h1);
        check("first_char_instr", 32'(issued_back(0)), 32'h141);
        check("first_char_cursor", 32'({Cursor_line, Cursor_position}), 32'h01);

        // Fill line 0 -> line-change to 0x0C0, then fill line 1 -> back to 0x080.
        for (int i = 0; i < 15; i++) send_char(0, 8'(8'h42 + i));
        check("wrap1_cursor", 32'({Cursor_line, Cursor_position}), 32'h10);
        check("wrap1_addr", 32'(issued_back(0)), 32'h0C0);
        check("wrap1_last_char", 32'(issued_back(1)), 32'h150);
        for (int i = 0; i < 16; i++) send_char(0, 8'(8'h61 + i));
        check("wrap2_cursor", 32'({Cursor_line, Cursor_position}), 32'h00);
        check("wrap2_addr", 32'(issued_back(0)), 32'h080);

        // Both requesters held: round-robin starts with requester 1.
        base       = grants.size();
        Req_data_0 = 8'h30;
        Req_data_1 = 8'h31;
        Req_char   = 2'b11;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock_50);
            if (grants.size() >= base + 4) break;
        end
        Req_char = 2'b00;
        wait_idle(100);
        check("rr_grant_count", 32'(grants.size() - base), 32'd4);
        if (grants.size() >= base + 4) begin
            check("rr_grant0", 32'(grants[base]), 32'h2);
            check("rr_grant1", 32'(grants[base + 1]), 32'h1);
            check("rr_grant2", 32'(grants[base + 2]), 32'h2);
            check("rr_grant3", 32'(grants[base + 3]), 32'h1);
        end
        check("rr_data0", 32'(issued_back(3)), 32'h131);
        check("rr_data1", 32'(issued_back(2)), 32'h130);
        check("rr_data2", 32'(issued_back(1)), 32'h131);
        check("rr_data3", 32'(issued_back(0)), 32'h130);

        // Walk the cursor from 4/0 to 5/1, then clear and char together.
        for (int i = 0; i < 17; i++) send_char(1, 8'h2E);
        check("pre_clear_cursor", 32'({Cursor_line, Cursor_position}), 32'h15);
        Req_data_1  = 8'h5A;
        Req_clear   = 1'b1;
        Req_char[1] = 1'b1;
        wait_grant(2, 20);
        Req_clear = 1'b0;
        wait_grant(1, 100);
        Req_char[1] = 1'b0;
        wait_idle(100);
        check("clear_grant", 32'(grants[grants.size() - 2]), 32'h4);
        check("char_after_clear_grant", 32'(grants[grants.size() - 1]), 32'h2);
        check("clear_instr", 32'(issued_back(2)), 32'h001);
        check("home_instr", 32'(issued_back(1)), 32'h080);
        check("char_after_clear_instr", 32'(issued_back(0)), 32'h15A);
        check("post_clear_cursor", 32'({Cursor_line, Cursor_position}), 32'h01);

        // Reset while waiting on a character's done.
        lcd_stall   = 1'b1;
        Req_data_0  = 8'h77;
        Req_char[0] = 1'b1;
        wait_grant(0, 20);
        Req_char[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock_50);
            if (LCD_start) break;
        end
        repeat (4) @(negedge Clock_50);
        check("stalled_busy", 32'(Busy), 32'd1);
        @(posedge Clock_50);
        #2 Resetn = 1'b0;
        #1;
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_busy", 32'(Busy), 32'd1);
        check("rst_init_done", 32'(Init_done), 32'd0);
        check("rst_start", 32'(LCD_start), 32'd0);
        check("rst_instr", 32'(LCD_instruction), 32'h000);
        check("rst_cursor", 32'({Cursor_line, Cursor_position}), 32'h00);
        base      = issued.size();
        lcd_stall = 1'b0;
        repeat (3) @(negedge Clock_50);
        @(posedge Clock_50);
        #2 Resetn = 1'b1;
        wait_init(300);
        check("reinit_start_count", 32'(issued.size() - base), 32'd5);
        if (issued.size() >= base + 5)
            for (int i = 0; i < 5; i++)
                check("reinit_sequence", 32'(issued[base + i]), 32'(init_tbl[i]));
        wait_idle(20);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
